// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch into a small
// prefetch FIFO feeding the IF/ID stage, with redirect flush of wrong-path work.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        IF_ID_Write,
    output logic        inst_valid,
    output logic [31:0] Inst,
    output logic [31:0] PCplus4
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc4_mem  [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] inflight_next;
    logic [CW:0]   credits_used;
    logic          xfer;
    logic          resp;
    logic          push;
    logic          pop;

    // Every buffered word and every outstanding request holds one credit, so
    // a response always finds a free FIFO slot.
    always_comb begin
        credits_used  = {1'b0, count} + {1'b0, inflight};
        imem_req      = !rst && (credits_used < (CW+1)'(DEPTH)) && !redirect;
        imem_addr     = fetch_pc;
        xfer          = imem_req && imem_gnt;
        resp          = imem_rvalid && (inflight != '0);
        push          = resp && (drop == '0) && !redirect;
        pop           = IF_ID_Write && (count != '0);
        inflight_next = inflight + CW'(xfer) - CW'(resp);
    end

    always_comb begin
        inst_valid = (count != '0);
        Inst       = inst_valid ? inst_mem[rd_ptr] : 32'h0;
        PCplus4    = inst_valid ? pc4_mem[rd_ptr]  : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect) begin
                // Everything still outstanding after this cycle is wrong-path.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= inflight_next;
            end else begin
                if (xfer)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp && (drop != '0))
                    drop <= drop - 1'b1;
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (!push && pop)
                    count <= count - 1'b1;
            end
        end
    end

    // NOTE: the payload array is not reset; count gates every read, so stale
    // contents are never visible and the storage stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc4_mem[wr_ptr]  <= resp_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: in-order memory model with
// programmable latency, directed redirect/stall/wrap/reset scenarios.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        IF_ID_Write;
    logic        inst_valid;
    logic [31:0] Inst;
    logic [31:0] PCplus4;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .IF_ID_Write(IF_ID_Write),
        .inst_valid (inst_valid),
        .Inst       (Inst),
        .PCplus4    (PCplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    // Scoreboard: expected {inst, pc+4} stream from the current fetch origin.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_from(input logic [31:0] pc);
        logic [31:0] a;
        exp_q.delete();
        a = pc;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back('{inst: mem_word(a), pc4: a + 32'd4});
            a = a + 32'd4;
        end
    endtask

    int pop_total = 0;

    always @(negedge clk) begin
        exp_t e;
        if (inst_valid && IF_ID_Write) begin
            pop_total++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underrun: got Inst %h with no expected entry", Inst);
            end else begin
                e = exp_q.pop_front();
                check("sb_inst", Inst, e.inst);
                check("sb_pc4", PCplus4, e.pc4);
            end
        end else if (!inst_valid) begin
            check("nop_inst", Inst, 32'h0);
            check("nop_pc4", PCplus4, 32'h0);
        end
    end

    // In-order instruction memory with fixed latency; cleared by rst.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t mq[$];
    int   lat         = 1;
    int   cyc         = 0;
    int   grant_total = 0;
    bit   spurious    = 1'b0;
    bit   real_rsp    = 1'b0;

    initial begin
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
            end else begin
                if (real_rsp && mq.size() > 0)
                    void'(mq.pop_front());
                if (imem_req && imem_gnt) begin
                    mq.push_back('{addr: imem_addr, due: cyc + lat});
                    grant_total++;
                end
            end
            cyc++;
            #1;
            real_rsp = 1'b0;
            if (spurious) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                spurious    = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mq[0].addr);
                real_rsp    = 1'b1;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Redirect asserted in the calling cycle R; returns at R+1 after checking.
    task automatic redirect_to(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        expect_from(pc);
        #1;
        check("redir_valid", 32'(inst_valid), 32'd0);
        check("redir_addr", imem_addr, pc);
        check("redir_req", 32'(imem_req), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        IF_ID_Write = 1'b1;

        cycles(3);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", Inst, 32'h0);
        check("rst_pc4", PCplus4, 32'h0);

        // Release reset: cycle 0 fetches RESET_PC combinationally.
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_from(RESET_PC);
        #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, RESET_PC);
        for (int k = 1; k <= 5; k++) begin
            cycles(1);
            check("seq_addr", imem_addr, RESET_PC + 32'(4 * k));
            if (k == 1)
                check("c1_valid", 32'(inst_valid), 32'd0);
            if (k == 2) begin
                check("c2_valid", 32'(inst_valid), 32'd1);
                check("c2_inst", Inst, mem_word(RESET_PC));
                check("c2_pc4", PCplus4, RESET_PC + 32'd4);
            end
        end

        p = pop_total;
        cycles(20);
        check("throughput", 32'(pop_total - p), 32'd20);

        // Stall: credits fill up, request stops, nothing lost on resume.
        IF_ID_Write = 1'b0;
        cycles(10);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_credits", 32'(grant_total - pop_total), 32'(DEPTH));
        IF_ID_Write = 1'b1;
        p = pop_total;
        cycles(8);
        check("resume_pops", 32'(pop_total - p), 32'd8);

        // Latency 3: build three in flight, then redirect over them.
        lat = 3;
        redirect_to(32'h0000_0040);
        cycles(3);
        check("inflight3", 32'(mq.size()), 32'd3);
        redirect_to(32'h0000_0100);
        for (int k = 2; k <= 5; k++) begin
            cycles(1);
            if (k < 5) begin
                check("stale_drop_valid", 32'(inst_valid), 32'd0);
            end else begin
                check("l3_first_valid", 32'(inst_valid), 32'd1);
                check("l3_first_inst", Inst, mem_word(32'h0000_0100));
                check("l3_first_pc4", PCplus4, 32'h0000_0104);
            end
        end
        p = pop_total;
        cycles(10);
        check("l3_progress", 32'(pop_total - p > 0), 32'd1);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        cycles(12);
        check("pre_rvalid", 32'(imem_rvalid), 32'd1);
        check("pre_valid", 32'(inst_valid), 32'd1);
        redirect_to(32'h0000_0200);
        p = pop_total;
        cycles(6);
        check("post_redir_progress", 32'(pop_total - p >= 3), 32'd1);

        // Address wrap at the top of the address space.
        redirect_to(32'hFFFF_FFF8);
        cycles(1);
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        cycles(1);
        check("wrap_addr2", imem_addr, 32'h0000_0000);
        p = pop_total;
        cycles(6);
        check("wrap_progress", 32'(pop_total - p >= 3), 32'd1);

        // Reset with buffered words and requests in flight.
        IF_ID_Write = 1'b0;
        lat = 3;
        redirect_to(32'h0000_0300);
        cycles(5);
        check("pre_rst_valid", 32'(inst_valid), 32'd1);
        check("pre_rst_inflight", 32'(mq.size()), 32'd2);
        rst = 1'b1;
        #1;
        check("rst_req_comb", 32'(imem_req), 32'd0);
        cycles(1);
        check("rst2_valid", 32'(inst_valid), 32'd0);
        check("rst2_req", 32'(imem_req), 32'd0);
        check("rst2_inst", Inst, 32'h0);
        check("rst2_pc4", PCplus4, 32'h0);
        lat      = 1;
        spurious = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        IF_ID_Write = 1'b1;
        expect_from(RESET_PC);
        #1;
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, RESET_PC);
        cycles(1);
        check("restart_addr1", imem_addr, RESET_PC + 32'd4);
        check("restart_c1_valid", 32'(inst_valid), 32'd0);
        cycles(1);
        check("restart_c2_valid", 32'(inst_valid), 32'd1);
        check("restart_c2_inst", Inst, mem_word(RESET_PC));
        p = pop_total;
        cycles(10);
        check("restart_pops", 32'(pop_total - p), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
